bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max bus cycles waited for bus_ack before abort (range 2..255).
REQ-002 SHALL have ports clk, input, 1, rising-edge clock.
REQ-003 SHALL have ports rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have ports flush, input, 1, pipeline flush from the pipeline controller.
REQ-005 SHALL have ports if_req, input, 1, and if_addr, input, 32: instruction fetch read request and address.
REQ-006 SHALL have ports if_rdata, output, 32, and if_ready, output, 1: fetch data and completion pulse.
REQ-007 SHALL have ports mem_req, input, 1; mem_we, input, 1; mem_sel, input, 4; mem_addr, input, 32; mem_wdata, input, 32: data-stage access.
REQ-008 SHALL have ports mem_rdata, output, 32, and mem_ready, output, 1: data-stage read data and completion pulse.
REQ-009 SHALL have ports bus_req, bus_we, output, 1; bus_sel, output, 4; bus_addr, bus_wdata, output, 32: shared single-port bus master side.
REQ-010 SHALL have ports bus_rdata, input, 32, and bus_ack, input, 1: bus slave response.
REQ-011 SHALL have ports stallreq_if, stallreq_mem, output, 1: stall requests to the pipeline controller.
REQ-012 SHALL have port bus_err, output, 1: one-cycle timeout pulse.

Function
REQ-013 SHALL implement FSM states IDLE, IF_XFER, MEM_XFER, DRAIN.
REQ-014 IDLE, flush=0: mem_req=1 -> MEM_XFER; else if_req=1 -> IF_XFER; MEM has strict priority.
REQ-015 IDLE, flush=1: all requests ignored that cycle.
REQ-016 On grant, address/we/sel/wdata SHALL be latched; bus_* outputs driven only from latched registers; bus_req=1 in XFER and DRAIN states only.
REQ-017 IF transfers SHALL drive bus_we=0, bus_sel=4'hF.
REQ-018 XFER with bus_ack=1, flush=0: bus_rdata latched into the granted rdata register; granted ready pulses 1 cycle in the next cycle; FSM -> IDLE. Minimum grant-to-ready latency: 2 cycles.
REQ-019 Writes SHALL pulse mem_ready likewise; mem_rdata unchanged.
REQ-020 XFER with flush=1 and bus_ack=0: FSM -> DRAIN; the bus cycle is not aborted.
REQ-021 DRAIN: wait for bus_ack; data discarded, no ready pulse; -> IDLE.
REQ-022 XFER with flush=1 and bus_ack=1 in the same cycle: transfer completes on the bus, data discarded, no ready pulse, -> IDLE.
REQ-023 A wait counter SHALL clear on entering XFER/DRAIN and increment each cycle without bus_ack.
REQ-024 Reaching TIMEOUT in XFER: bus_err pulses; granted ready pulses with rdata=0; FSM -> IDLE.
REQ-025 Reaching TIMEOUT in DRAIN: bus_err pulses; FSM -> IDLE; no ready pulse.
REQ-026 stallreq_mem = mem_req & ~mem_ready; stallreq_if = if_req & ~if_ready. Both combinational and forced to 0 during rst.
REQ-027 Requesters SHALL hold req/addr until ready. The arbiter re-samples req only in IDLE, so a req still high the cycle after ready starts a new transfer.

Reset
REQ-028 rst=1 at a clock edge: FSM=IDLE; counter=0; all ready, bus_req, bus_we, bus_err=0; bus_sel=0; bus_addr, bus_wdata, if_rdata, mem_rdata=32'h0.
REQ-029 rst mid-transfer SHALL abandon the bus cycle immediately; a late bus_ack in IDLE is ignored.

Structure
REQ-030 The shared defines package SHALL hold state encodings and the 32-bit bus width, reusing the existing RegBus/ZeroWord/Stop definitions.
REQ-031 The timeout counter SHALL be a sub-module bus_wdog (clear, enable, expire); the rest stays flat.

Verification
REQ-032 if_req only, addr 32'h00400000, ack 3 cycles after bus_req with 32'h24020001 -> if_ready one cycle, if_rdata=32'h24020001, stallreq_if low after.
REQ-033 if_req and mem_req (we=1, sel=4'hF, addr 32'h10010000, wdata 32'hDEADBEEF) in the same cycle -> MEM granted first with bus_we=1; IF served next; stallreq_if high throughout.
REQ-034 flush 1 cycle into an IF transfer, ack 2 cycles later -> DRAIN, no if_ready, then IDLE.
REQ-035 No ack, TIMEOUT=16 -> bus_err and mem_ready pulse on wait cycle 16, mem_rdata=0.
REQ-036 rst asserted mid-MEM_XFER, ack arrives next cycle -> all outputs at reset values, no ready pulse.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the instruction/data bus arbiter: bus width,
// common word constants, stall encoding and the arbiter state encoding.
package bus_arbiter_pkg;

  localparam int RegBus = 32;
  localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam int WdogW = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_XFER  = 2'd1,
    MEM_XFER = 2'd2,
    DRAIN    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/bus_wdog.sv
// Bus watchdog: counts cycles spent waiting for bus_ack and flags the
// cycle in which the wait reaches TIMEOUT.
module bus_wdog
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [WdogW-1:0] count;

  // Wait counter: restarted on clear, advanced on every ack-less bus cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // This ack-less cycle is the TIMEOUT-th one, so the wait ends here.
  assign expire = enable && (count == WdogW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Arbiter sharing one single-port bus between instruction fetch and the
// data stage. Data accesses win over fetches, flushes turn a running fetch
// into a drained bus cycle, and a watchdog aborts cycles the slave never acks.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_req,
  input  logic [RegBus-1:0] if_addr,
  output logic [RegBus-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_sel,
  input  logic [RegBus-1:0] mem_addr,
  input  logic [RegBus-1:0] mem_wdata,
  output logic [RegBus-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [RegBus-1:0] bus_addr,
  output logic [RegBus-1:0] bus_wdata,
  input  logic [RegBus-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              stallreq_if,
  output logic              stallreq_mem,
  output logic              bus_err
);

  arb_state_t state;
  logic       wdog_clear;
  logic       wdog_enable;
  logic       wdog_expire;

  // The counter sits at zero while idle and restarts when a flush diverts a
  // transfer into the drain state.
  assign wdog_clear  = (state == IDLE) ||
                       (((state == IF_XFER) || (state == MEM_XFER)) && flush && !bus_ack);
  assign wdog_enable = (state != IDLE) && !bus_ack;

  bus_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .clear (wdog_clear),
    .enable(wdog_enable),
    .expire(wdog_expire)
  );

  // Arbitration FSM with all bus-side and completion outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= 4'h0;
      bus_addr  <= ZeroWord;
      bus_wdata <= ZeroWord;
      if_rdata  <= ZeroWord;
      mem_rdata <= ZeroWord;
      bus_err   <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush) begin
            if (mem_req) begin
              state     <= MEM_XFER;
              bus_req   <= 1'b1;
              bus_we    <= mem_we;
              bus_sel   <= mem_sel;
              bus_addr  <= mem_addr;
              bus_wdata <= mem_wdata;
            end else if (if_req) begin
              state     <= IF_XFER;
              bus_req   <= 1'b1;
              bus_we    <= 1'b0;
              bus_sel   <= 4'hF;
              bus_addr  <= if_addr;
              bus_wdata <= ZeroWord;
            end
          end
        end
        IF_XFER, MEM_XFER: begin
          if (bus_ack) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            if (!flush) begin
              if (state == IF_XFER) begin
                if_rdata <= bus_rdata;
                if_ready <= 1'b1;
              end else begin
                if (!bus_we) begin
                  mem_rdata <= bus_rdata;
                end
                mem_ready <= 1'b1;
              end
            end
          end else if (flush) begin
            state <= DRAIN;
          end else if (wdog_expire) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            bus_err <= 1'b1;
            if (state == IF_XFER) begin
              if_rdata <= ZeroWord;
              if_ready <= 1'b1;
            end else begin
              mem_rdata <= ZeroWord;
              mem_ready <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bus_ack) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
          end else if (wdog_expire) begin
            state   <= IDLE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            bus_err <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
          bus_we  <= 1'b0;
        end
      endcase
    end
  end

  assign stallreq_if  = (!rst && if_req && !if_ready) ? Stop : NoStop;
  assign stallreq_mem = (!rst && mem_req && !mem_ready) ? Stop : NoStop;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a cycle-by-cycle vector table for the
// normal transfers and flush cases, plus hand-built timeout and reset runs.
module tb_bus_arbiter;

  localparam int TIMEOUT = 16;

  localparam logic [31:0] A_IF  = 32'h0040_0000;
  localparam logic [31:0] A_IF2 = 32'h0040_0004;
  localparam logic [31:0] A_IF3 = 32'h0040_0010;
  localparam logic [31:0] D_IF  = 32'h2402_0001;
  localparam logic [31:0] D_IF2 = 32'h8C42_0004;
  localparam logic [31:0] A_M   = 32'h1001_0000;
  localparam logic [31:0] A_M2  = 32'h1001_0008;
  localparam logic [31:0] D_M   = 32'hDEAD_BEEF;
  localparam logic [31:0] D_RD  = 32'hCAFE_F00D;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stallreq_if;
  logic        stallreq_mem;
  logic        bus_err;

  always #5 clk = ~clk;

  bus_arbiter #(
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_ready    (if_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_sel     (mem_sel),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_sel     (bus_sel),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_ack     (bus_ack),
    .stallreq_if (stallreq_if),
    .stallreq_mem(stallreq_mem),
    .bus_err     (bus_err)
  );

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
  } in_t;

  typedef struct packed {
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        stallreq_if;
    logic        stallreq_mem;
    logic        bus_err;
  } out_t;

  typedef struct {
    string name;
    in_t   stim;
    out_t  want;
  } vec_t;

  vec_t vecs[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  function automatic in_t si(logic r, logic fl, logic ir, logic [31:0] ia,
                             logic mr, logic mw, logic [3:0] ms, logic [31:0] ma,
                             logic [31:0] md, logic [31:0] rd, logic ack);
    in_t v;
    v.rst       = r;
    v.flush     = fl;
    v.if_req    = ir;
    v.if_addr   = ia;
    v.mem_req   = mr;
    v.mem_we    = mw;
    v.mem_sel   = ms;
    v.mem_addr  = ma;
    v.mem_wdata = md;
    v.bus_rdata = rd;
    v.bus_ack   = ack;
    return v;
  endfunction

  function automatic out_t so(logic irdy, logic [31:0] ird, logic mrdy, logic [31:0] mrd,
                              logic breq, logic bwe, logic [3:0] bsel, logic [31:0] baddr,
                              logic [31:0] bwd, logic sif, logic smem, logic berr);
    out_t v;
    v.if_ready     = irdy;
    v.if_rdata     = ird;
    v.mem_ready    = mrdy;
    v.mem_rdata    = mrd;
    v.bus_req      = breq;
    v.bus_we       = bwe;
    v.bus_sel      = bsel;
    v.bus_addr     = baddr;
    v.bus_wdata    = bwd;
    v.stallreq_if  = sif;
    v.stallreq_mem = smem;
    v.bus_err      = berr;
    return v;
  endfunction

  task automatic addVec(input string name, input in_t s, input out_t w);
    vec_t v;
    v.name = name;
    v.stim = s;
    v.want = w;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input in_t s);
    rst       = s.rst;
    flush     = s.flush;
    if_req    = s.if_req;
    if_addr   = s.if_addr;
    mem_req   = s.mem_req;
    mem_we    = s.mem_we;
    mem_sel   = s.mem_sel;
    mem_addr  = s.mem_addr;
    mem_wdata = s.mem_wdata;
    bus_rdata = s.bus_rdata;
    bus_ack   = s.bus_ack;
  endtask

  task automatic checkValue(input string name, input string sig,
                            input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", name, sig, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input out_t w);
    checkValue(name, "if_ready",     32'(if_ready),     32'(w.if_ready));
    checkValue(name, "if_rdata",     if_rdata,          w.if_rdata);
    checkValue(name, "mem_ready",    32'(mem_ready),    32'(w.mem_ready));
    checkValue(name, "mem_rdata",    mem_rdata,         w.mem_rdata);
    checkValue(name, "bus_req",      32'(bus_req),      32'(w.bus_req));
    checkValue(name, "bus_we",       32'(bus_we),       32'(w.bus_we));
    checkValue(name, "bus_sel",      32'(bus_sel),      32'(w.bus_sel));
    checkValue(name, "bus_addr",     bus_addr,          w.bus_addr);
    checkValue(name, "bus_wdata",    bus_wdata,         w.bus_wdata);
    checkValue(name, "stallreq_if",  32'(stallreq_if),  32'(w.stallreq_if));
    checkValue(name, "stallreq_mem", 32'(stallreq_mem), 32'(w.stallreq_mem));
    checkValue(name, "bus_err",      32'(bus_err),      32'(w.bus_err));
  endtask

  // One cycle: inputs change on the falling edge, outputs are sampled 1ns
  // later, well before the next rising edge.
  task automatic runVector(input string name, input in_t s, input out_t w);
    @(negedge clk);
    applyStimulus(s);
    #1;
    checkOutput(name, w);
  endtask

  initial begin
    in_t  idle_in;
    out_t w;

    idle_in = si(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);

    // Reset hold; stall requests must stay low even with both requests up.
    addVec("reset_hold", si(1, 0, 1, A_IF, 1, 0, 4'hF, A_M, 0, 0, 0),
           so(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0));
    // Fetch with the ack arriving on the third bus_req cycle after the first.
    addVec("if_grant", si(0, 0, 1, A_IF, 0, 0, 4'h0, 0, 0, 0, 0),
           so(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      addVec("if_wait", si(0, 0, 1, A_IF, 0, 0, 4'h0, 0, 0, 0, 0),
             so(0, 0, 0, 0, 1, 0, 4'hF, A_IF, 0, 1, 0, 0));
    addVec("if_ack", si(0, 0, 1, A_IF, 0, 0, 4'h0, 0, 0, D_IF, 1),
           so(0, 0, 0, 0, 1, 0, 4'hF, A_IF, 0, 1, 0, 0));
    // Request still high during ready: stall masked, new fetch granted.
    addVec("if_ready_regrant", si(0, 0, 1, A_IF2, 0, 0, 4'h0, 0, 0, 0, 0),
           so(1, D_IF, 0, 0, 0, 0, 4'hF, A_IF, 0, 0, 0, 0));
    addVec("if2_ack", si(0, 0, 1, A_IF2, 0, 0, 4'h0, 0, 0, D_IF2, 1),
           so(0, D_IF, 0, 0, 1, 0, 4'hF, A_IF2, 0, 1, 0, 0));
    addVec("if2_ready", idle_in,
           so(1, D_IF2, 0, 0, 0, 0, 4'hF, A_IF2, 0, 0, 0, 0));
    addVec("if_idle", idle_in,
           so(0, D_IF2, 0, 0, 0, 0, 4'hF, A_IF2, 0, 0, 0, 0));
    // Simultaneous requests: the data-stage write goes first.
    addVec("both_req", si(0, 0, 1, A_IF, 1, 1, 4'hF, A_M, D_M, 0, 0),
           so(0, D_IF2, 0, 0, 0, 0, 4'hF, A_IF2, 0, 1, 1, 0));
    addVec("mem_wr_ack", si(0, 0, 1, A_IF, 1, 1, 4'hF, A_M, D_M, 32'h1234_5678, 1),
           so(0, D_IF2, 0, 0, 1, 1, 4'hF, A_M, D_M, 1, 1, 0));
    addVec("mem_wr_ready", si(0, 0, 1, A_IF, 0, 0, 4'h0, 0, 0, 0, 0),
           so(0, D_IF2, 1, 0, 0, 0, 4'hF, A_M, D_M, 1, 0, 0));
    addVec("if_after_mem", si(0, 0, 1, A_IF, 0, 0, 4'h0, 0, 0, D_IF, 1),
           so(0, D_IF2, 0, 0, 1, 0, 4'hF, A_IF, 0, 1, 0, 0));
    addVec("if_after_mem_ready", idle_in,
           so(1, D_IF, 0, 0, 0, 0, 4'hF, A_IF, 0, 0, 0, 0));
    // Partial-select data read with the fastest possible ack.
    addVec("mem_rd_grant", si(0, 0, 0, 0, 1, 0, 4'h3, A_M2, 0, 0, 0),
           so(0, D_IF, 0, 0, 0, 0, 4'hF, A_IF, 0, 0, 1, 0));
    addVec("mem_rd_ack", si(0, 0, 0, 0, 1, 0, 4'h3, A_M2, 0, D_RD, 1),
           so(0, D_IF, 0, 0, 1, 0, 4'h3, A_M2, 0, 0, 1, 0));
    addVec("mem_rd_ready", idle_in,
           so(0, D_IF, 1, D_RD, 0, 0, 4'h3, A_M2, 0, 0, 0, 0));
    // Flush one cycle into a fetch; ack two cycles later is drained silently.
    addVec("flush_grant", si(0, 0, 1, A_IF3, 0, 0, 4'h0, 0, 0, 0, 0),
           so(0, D_IF, 0, D_RD, 0, 0, 4'h3, A_M2, 0, 1, 0, 0));
    addVec("flush_xfer", si(0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0),
           so(0, D_IF, 0, D_RD, 1, 0, 4'hF, A_IF3, 0, 0, 0, 0));
    addVec("drain_wait", idle_in,
           so(0, D_IF, 0, D_RD, 1, 0, 4'hF, A_IF3, 0, 0, 0, 0));
    addVec("drain_ack", si(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'hBAD0_BAD0, 1),
           so(0, D_IF, 0, D_RD, 1, 0, 4'hF, A_IF3, 0, 0, 0, 0));
    // Flush while idle blocks the grant for that cycle only.
    addVec("drain_done_flush_idle", si(0, 1, 1, A_IF, 0, 0, 4'h0, 0, 0, 0, 0),
           so(0, D_IF, 0, D_RD, 0, 0, 4'hF, A_IF3, 0, 1, 0, 0));
    addVec("flush_ignored", si(0, 0, 1, A_IF, 0, 0, 4'h0, 0, 0, 0, 0),
           so(0, D_IF, 0, D_RD, 0, 0, 4'hF, A_IF3, 0, 1, 0, 0));
    // Flush and ack together: bus cycle completes, data dropped.
    addVec("flush_with_ack", si(0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 32'h1111_1111, 1),
           so(0, D_IF, 0, D_RD, 1, 0, 4'hF, A_IF, 0, 0, 0, 0));
    addVec("flush_ack_done", idle_in,
           so(0, D_IF, 0, D_RD, 0, 0, 4'hF, A_IF, 0, 0, 0, 0));

    applyStimulus(si(1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++)
      runVector(vecs[i].name, vecs[i].stim, vecs[i].want);

    // Data read that is never acked: bus_req stays up for TIMEOUT cycles,
    // then bus_err and mem_ready pulse together with zeroed read data.
    runVector("to_grant", si(0, 0, 0, 0, 1, 0, 4'hF, A_M, 0, 0, 0),
              so(0, D_IF, 0, D_RD, 0, 0, 4'hF, A_IF, 0, 0, 1, 0));
    for (int i = 1; i <= TIMEOUT; i++)
      runVector($sformatf("to_wait%0d", i), si(0, 0, 0, 0, 1, 0, 4'hF, A_M, 0, 0, 0),
                so(0, D_IF, 0, D_RD, 1, 0, 4'hF, A_M, 0, 0, 1, 0));
    // A new write request is already waiting as the timeout completes.
    runVector("to_expire", si(0, 0, 0, 0, 1, 1, 4'hF, A_M, D_M, 0, 0),
              so(0, D_IF, 1, 0, 0, 0, 4'hF, A_M, 0, 0, 0, 1));
    runVector("rst_xfer", si(0, 0, 0, 0, 1, 1, 4'hF, A_M, D_M, 0, 0),
              so(0, D_IF, 0, 0, 1, 1, 4'hF, A_M, D_M, 0, 1, 0));
    // Reset mid-transfer; the late ack afterwards must be ignored.
    runVector("rst_assert", si(1, 0, 0, 0, 1, 1, 4'hF, A_M, D_M, 0, 0),
              so(0, D_IF, 0, 0, 1, 1, 4'hF, A_M, D_M, 0, 0, 0));
    w = so(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
    runVector("rst_late_ack", si(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h55AA_55AA, 1), w);
    runVector("rst_after", idle_in, w);

    // Drained fetch that is never acked: bus_err without if_ready.
    runVector("dto_grant", si(0, 0, 1, A_IF, 0, 0, 4'h0, 0, 0, 0, 0),
              so(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 0));
    w = so(0, 0, 0, 0, 1, 0, 4'hF, A_IF, 0, 0, 0, 0);
    runVector("dto_flush", si(0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0), w);
    for (int i = 1; i <= TIMEOUT; i++)
      runVector($sformatf("dto_wait%0d", i), idle_in, w);
    runVector("dto_expire", idle_in, so(0, 0, 0, 0, 0, 0, 4'hF, A_IF, 0, 0, 0, 1));
    runVector("dto_idle", idle_in, so(0, 0, 0, 0, 0, 0, 4'hF, A_IF, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
